// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and types for the front-end pipeline stages.
//   - RISC-V register-index field positions, used for early hazard lookup.
//   - Default NOP encoding (addi x0, x0, 0).
//   - if_id_payload_t: default-width {pc, instr} bundle carried from fetch
//     to decode.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int REG_IDX_W = 5;

    localparam int PC_W_DEFAULT    = 32;
    localparam int INSTR_W_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]    pc;
        logic [INSTR_W_DEFAULT-1:0] instr;
    } if_id_payload_t;

endpackage : pipe_pkg

// File: rtl/skid_buffer.sv
// ----------------------------------------------------------------------------
// skid_buffer
//   Generic two-entry valid/ready buffer over a packed payload. The main
//   entry drives the output; the skid entry catches the one extra beat that
//   can arrive while the consumer stalls. in_ready comes straight from the
//   skid-valid flop, so there is no combinational path from out_ready to
//   in_ready.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     flush               drop every held entry and any entry accepted now
//     in_valid/in_ready   producer handshake (in_ready registered)
//     in_data  [W]        producer payload
//     out_valid/out_ready consumer handshake
//     out_data [W]        consumer payload (main entry)
// ----------------------------------------------------------------------------
module skid_buffer #(
    parameter int           W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid_q, m_valid_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] m_data_q,  m_data_d;
    logic [W-1:0] s_data_q,  s_data_d;

    logic acc;
    logic pop;

    assign in_ready  = ~s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    assign acc = in_valid & ~s_valid_q;
    assign pop = m_valid_q & out_ready;

    // The skid entry is only ever occupied while the main entry is, so an
    // empty main entry implies an empty skid entry.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;

        if (flush) begin
            // A pop in the same cycle has already been taken by the consumer;
            // clearing here just makes sure it is not presented again.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_data_d  = RST_VAL;
        end else if (!m_valid_q) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end
        end else if (pop) begin
            if (s_valid_q) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (acc) begin
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= RST_VAL;
            s_data_q  <= RST_VAL;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule : skid_buffer

// File: rtl/if_id_skid_stage.sv
// ----------------------------------------------------------------------------
// if_id_skid_stage
//   IF/ID pipeline stage built on a two-entry skid buffer. Carries PC and
//   instruction from fetch to decode, substitutes NOP_INSTR on out_instr
//   whenever nothing valid is held, and exposes the rs1/rs2 indices of the
//   instruction currently presented by fetch for early hazard detection.
//
//   Ports:
//     CLK, Resetn          clock, asynchronous active-low reset
//     flush                discard held and incoming entries
//     in_valid/in_ready    fetch handshake (in_ready registered)
//     in_pc, in_instr      fetch payload
//     out_valid/out_ready  decode handshake
//     out_pc, out_instr    decode payload (out_instr = NOP_INSTR if invalid)
//     id_ra, id_rb         in_instr[19:15], in_instr[24:20] (combinational)
//
//   Optional (macro IF_ID_SKID_STAGE_STATS_EN):
//     stall_cnt [32]       cycles with out_valid & ~out_ready (wraps)
//     flush_cnt [16]       cycles with flush asserted (wraps)
// ----------------------------------------------------------------------------
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic                 CLK,
    input  logic                 Resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [INSTR_W-1:0]   in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [REG_IDX_W-1:0] id_ra,
    output logic [REG_IDX_W-1:0] id_rb
`ifdef IF_ID_SKID_STAGE_STATS_EN
   ,output logic [31:0]          stall_cnt,
    output logic [15:0]          flush_cnt
`endif
);

    localparam int PL_W = PC_W + INSTR_W;
    localparam logic [PL_W-1:0] PL_RST = {{PC_W{1'b0}}, NOP_INSTR};

    logic [PL_W-1:0] in_data;
    logic [PL_W-1:0] out_data;
    logic [INSTR_W-1:0] held_instr;

    assign in_data = {in_pc, in_instr};

    skid_buffer #(
        .W       (PL_W),
        .RST_VAL (PL_RST)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (Resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_pc     = out_data[PL_W-1 -: PC_W];
    assign held_instr = out_data[INSTR_W-1:0];
    assign out_instr  = out_valid ? held_instr : NOP_INSTR;

    // Early register indices straight off the fetch bus; hazard logic
    // qualifies them with in_valid itself.
    assign id_ra = in_instr[RS1_LSB +: REG_IDX_W];
    assign id_rb = in_instr[RS2_LSB +: REG_IDX_W];

`ifdef IF_ID_SKID_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush)                   flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : if_id_skid_stage

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus random traffic,
// checked against a queue model of a two-deep in-order FIFO.
module tb_if_id_skid_stage;
    import pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        Resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
`ifdef IF_ID_SKID_STAGE_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    int unsigned stall_m, flush_m;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_id_payload_t mq[$];

    always #5 CLK = ~CLK;

    if_id_skid_stage dut (
        .CLK       (CLK),
        .Resetn    (Resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .id_ra     (id_ra),
        .id_rb     (id_rb)
`ifdef IF_ID_SKID_STAGE_STATS_EN
       ,.stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_pc",    64'(out_pc),    64'(mq[0].pc));
            chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
        end else begin
            chk("out_instr_nop", 64'(out_instr), 64'(NOP));
        end
`ifdef IF_ID_SKID_STAGE_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
    endtask

    // Apply one cycle of inputs (called just after a negedge), advance the
    // model by the same edge, then check at the following negedge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        bit do_acc, do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("id_ra", 64'(id_ra), 64'((ins >> 15) & 32'h1f));
        chk("id_rb", 64'(id_rb), 64'((ins >> 20) & 32'h1f));
`ifdef IF_ID_SKID_STAGE_STATS_EN
        if (mq.size() > 0 && !ordy) stall_m++;
        if (fl) flush_m = (flush_m + 1) & 16'hffff;
`endif
        do_acc = iv && (mq.size() < 2);
        do_pop = (mq.size() > 0) && ordy;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_acc) mq.push_back('{pc: pc, instr: ins});
        end
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        Resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = NOP;
`ifdef IF_ID_SKID_STAGE_STATS_EN
        stall_m = 0; flush_m = 0;
`endif
        repeat (2) @(negedge CLK);
        check_outputs();
        Resetn = 1'b1;
        @(negedge CLK);
        check_outputs();

        // Streaming at full throughput.
        step(1, 32'h0, 32'h0000_0093, 1, 0);
        step(1, 32'h4, 32'h0010_0113, 1, 0);
        step(1, 32'h8, 32'h0020_0193, 1, 0);
        step(0, 32'h0, NOP, 1, 0);

        // Stall fills main then skid; release drains in order.
        step(1, 32'h10, 32'h0041_0233, 0, 0);
        step(1, 32'h14, 32'h0052_02b3, 0, 0);
        step(1, 32'h18, 32'h0063_0333, 0, 0);   // ignored, in_ready=0
        step(0, 32'h0, NOP, 1, 0);
        step(0, 32'h0, NOP, 1, 0);
        step(0, 32'h0, NOP, 1, 0);

        // Flush with both entries held and a new entry offered.
        step(1, 32'h10, 32'h0041_0233, 0, 0);
        step(1, 32'h14, 32'h0052_02b3, 0, 0);
        step(1, 32'h20, 32'h0073_03b3, 0, 1);
        step(0, 32'h0, NOP, 1, 0);

        // Flush coinciding with a pop and an acceptance.
        step(1, 32'h30, 32'h0083_0433, 1, 0);
        step(1, 32'h34, 32'h0093_04b3, 1, 1);
        step(0, 32'h0, NOP, 1, 0);

        // Field extraction without in_valid.
        step(0, 32'h0, 32'h00B5_0533, 1, 0);
        chk("id_ra_dir", 64'(id_ra), 64'd10);
        chk("id_rb_dir", 64'(id_rb), 64'd11);

        // Build up state then reset asynchronously mid-stream.
        step(1, 32'h40, 32'h0000_0013, 0, 0);
        step(1, 32'h44, 32'h0000_0013, 0, 0);
        in_valid = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        mq.delete();
`ifdef IF_ID_SKID_STAGE_STATS_EN
        stall_m = 0; flush_m = 0;
`endif
        check_outputs();
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge CLK);
        Resetn = 1'b1;
        @(negedge CLK);
        check_outputs();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 $urandom & 32'hffff_fffc,
                 $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_if_id_skid_stage

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised successor to the fixed IF/ID latch: a two-entry skid-buffered pipeline stage between fetch and decode.
- Carries PC and instruction with valid/ready handshakes on both sides, plus a flush input.
- `in_ready` is driven only from a flop, which breaks the combinational stall path from decode back to fetch.
- Also exposes the early rs1/rs2 indices of the incoming instruction for hazard detection.

Parameters:
- PC_W, 32, width of program-counter payload
- INSTR_W, 32, width of instruction payload (>= 25)
- NOP_INSTR, 32'h0000_0013, value driven on out_instr whenever out_valid=0

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept; registered
- in_pc  in  PC_W  fetch PC
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  decode entry valid
- out_ready  in  1  decode consumes the entry
- out_pc  out  PC_W  decode PC
- out_instr  out  INSTR_W  decode instruction (NOP_INSTR when invalid)
- id_ra  out  5  in_instr[19:15], combinational
- id_rb  out  5  in_instr[24:20], combinational

Behaviour:
- Storage: main entry (m_valid, m_pc, m_instr) and skid entry (s_valid, s_pc, s_instr).
- Output mapping:
  - out_valid = m_valid
  - out_pc = m_pc
  - out_instr = m_valid ? m_instr : NOP_INSTR
  - in_ready = ~s_valid (flop-sourced)
- Reset (async, Resetn=0):
  - m_valid = s_valid = 0
  - m_pc = s_pc = 0
  - m_instr = s_instr = NOP_INSTR
  - Hence out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1.
  - Reset asserted mid-transfer drops all entries immediately.
- Handshake events:
  - acc = in_valid & in_ready
  - pop = m_valid & out_ready
- Latency: one cycle from acceptance to out_valid when the stage is empty.
- Per-edge transitions (flush=0):
  - m empty, acc: m <= in.
  - m full, pop, no acc, s empty: m_valid <= 0.
  - m full, pop, acc, s empty: m <= in (back-to-back streaming, full throughput).
  - m full, no pop, acc: s <= in, s_valid <= 1; in_ready drops next cycle.
  - m full, pop, s full: m <= s, s_valid <= 0 (acc impossible since in_ready=0).
  - m full, no pop, s full: hold everything.
- Ordering: entries leave in acceptance order; no loss or duplication.
- in_valid while in_ready=0: ignored. Fetch must hold its payload until acceptance.
- Flush has priority over everything:
  - m_valid <= 0, s_valid <= 0, m_instr <= NOP_INSTR.
  - An entry accepted in the same cycle (acc=1) is discarded.
  - in_ready = 1 on the following cycle.
- flush and pop in the same cycle: decode's consumption stands; the entry is not replayed.
- id_ra/id_rb are purely combinational on in_instr, independent of valid and reset.

Optional Feature:
- Macro: IF_ID_SKID_STAGE_STATS_EN
- With the macro defined, two extra output ports are added:
  - stall_cnt (32b): increments each cycle with m_valid & ~out_ready.
  - flush_cnt (16b): increments each cycle flush=1.
  - Both counters reset to 0 asynchronously and wrap silently at all-ones → 0.
- Without the macro: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - RISC-V field-position constants RS1_LSB=15, RS2_LSB=20, REG_IDX_W=5.
  - Default NOP_INSTR constant.
  - Typedef if_id_payload_t {pc, instr}.
- One natural sub-module, skid_buffer: generic two-entry valid/ready buffer over a packed payload.
- if_id_skid_stage wraps skid_buffer and adds NOP substitution, field extraction and the optional counters.

Test Plan:
- Reset: Resetn=0 mid-stream → out_valid=0, out_instr=0x00000013, out_pc=0, in_ready=1 asynchronously, before the next edge.
- Streaming: out_ready=1, PCs 0x0,0x4,0x8 with valid every cycle → appear on out_pc one cycle later each, no gaps, in_ready stays 1.
- Stall/skid:
  - Apply out_ready=0 while sending 0x10 then 0x14 → out_pc=0x10 held, in_ready=0 after 0x14 accepted.
  - Then out_ready=1 → 0x10, 0x14 popped in order, in_ready returns to 1.
- Flush with full skid: both entries held, flush=1 with in_valid (0x20) → next cycle out_valid=0, out_instr=NOP, in_ready=1, 0x20 never appears.
- Field extraction: in_instr=0x00B50533 → id_ra=10, id_rb=11 in the same cycle, regardless of in_valid.
- Stats (macro on): 3 stall cycles, 2 flush cycles → stall_cnt=3, flush_cnt=2; preload stall_cnt near 0xFFFFFFFF and confirm it wraps to 0.
